// File: rtl/usb_frame_dispatcher_if.sv
// Byte-stream, register-write and CCW FIFO signals of the frame dispatcher.
// slave: the dispatcher itself; master: the surrounding decoder/FIFO/regfile side.
interface usb_frame_dispatcher_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        reg_wr_en;
    logic [7:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        ccw_full;
    logic        ccw_wr;
    logic [7:0]  ccw_data;
    logic [15:0] ccw_len;
    logic        ccw_len_vld;
    logic        frame_done;
    logic        len_err;
    logic        ovf_err;

    modport slave (
        input  in_data, in_valid, ccw_full,
        output reg_wr_en, reg_wr_addr, reg_wr_data, ccw_wr, ccw_data, ccw_len, ccw_len_vld,
               frame_done, len_err, ovf_err
    );

    modport master (
        output in_data, in_valid, ccw_full,
        input  reg_wr_en, reg_wr_addr, reg_wr_data, ccw_wr, ccw_data, ccw_len, ccw_len_vld,
               frame_done, len_err, ovf_err
    );
endinterface

// File: rtl/usb_frame_dispatcher.sv
// Routes de-framed USB payload frames: the CCW address streams length-checked data into the
// CCW FIFO, any other address turns the frame into auto-incrementing register writes.
// Every output is registered; a byte sampled on an edge shows up on the outputs after that edge.
module usb_frame_dispatcher #(
    parameter logic [7:0]  CCW_ADDR    = 8'h01,
    parameter logic [15:0] MAX_CCW_LEN = 16'd120
) (
    input logic                  clk,
    input logic                  n_rst,
    usb_frame_dispatcher_if.slave bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LEN_H    = 3'd1;
    localparam logic [2:0] LEN_L    = 3'd2;
    localparam logic [2:0] CCW_DATA = 3'd3;
    localparam logic [2:0] REG_DATA = 3'd4;
    localparam logic [2:0] DROP     = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic [7:0]  reg_wr_addr_q, reg_wr_addr_d;
    logic [7:0]  reg_wr_data_q, reg_wr_data_d;
    logic        ccw_wr_q, ccw_wr_d;
    logic [7:0]  ccw_data_q, ccw_data_d;
    logic [15:0] ccw_len_q, ccw_len_d;
    logic        ccw_len_vld_q, ccw_len_vld_d;
    logic        frame_done_q, frame_done_d;
    logic        len_err_q, len_err_d;
    logic        ovf_err_q, ovf_err_d;
    logic [15:0] len_full;

    // Complete declared length as soon as the low length byte is on the bus.
    assign len_full = {len_q[15:8], bus.in_data};

    // Next-state: frame parsing, routing and per-frame error tracking.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        ccw_wr_d      = 1'b0;
        ccw_data_d    = ccw_data_q;
        ccw_len_d     = ccw_len_q;
        ccw_len_vld_d = 1'b0;
        frame_done_d  = 1'b0;
        len_err_d     = len_err_q;
        ovf_err_d     = ovf_err_q;

        if (state_q != IDLE && !bus.in_valid) begin
            // Gap after a frame: report it and flag a CCW frame cut short of its length.
            frame_done_d = 1'b1;
            state_d      = IDLE;
            if (state_q == LEN_H || state_q == LEN_L ||
                (state_q == CCW_DATA && cnt_q < len_q)) begin
                len_err_d = 1'b1;
            end
        end else if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    addr_d    = bus.in_data;
                    len_d     = '0;
                    cnt_d     = '0;
                    len_err_d = 1'b0;
                    ovf_err_d = 1'b0;
                    state_d   = (bus.in_data == CCW_ADDR) ? LEN_H : REG_DATA;
                end
                LEN_H: begin
                    len_d[15:8] = bus.in_data;
                    state_d     = LEN_L;
                end
                LEN_L: begin
                    len_d = len_full;
                    if (len_full == 16'd0 || len_full > MAX_CCW_LEN) begin
                        len_err_d = 1'b1;
                        state_d   = DROP;
                    end else begin
                        ccw_len_vld_d = 1'b1;
                        ccw_len_d     = len_full;
                        cnt_d         = '0;
                        state_d       = CCW_DATA;
                    end
                end
                CCW_DATA: begin
                    if (cnt_q < len_q) begin
                        // Counted even when the FIFO is full so truncation stays detectable.
                        cnt_d = cnt_q + 16'd1;
                        if (!bus.ccw_full) begin
                            ccw_wr_d   = 1'b1;
                            ccw_data_d = bus.in_data;
                        end else begin
                            ovf_err_d = 1'b1;
                        end
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
                REG_DATA: begin
                    reg_wr_en_d   = 1'b1;
                    reg_wr_addr_d = addr_q;
                    reg_wr_data_d = bus.in_data;
                    addr_d        = addr_q + 8'd1;
                end
                DROP: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs; reset aborts any frame without a frame_done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            ccw_wr_q      <= 1'b0;
            ccw_data_q    <= '0;
            ccw_len_q     <= '0;
            ccw_len_vld_q <= 1'b0;
            frame_done_q  <= 1'b0;
            len_err_q     <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            ccw_wr_q      <= ccw_wr_d;
            ccw_data_q    <= ccw_data_d;
            ccw_len_q     <= ccw_len_d;
            ccw_len_vld_q <= ccw_len_vld_d;
            frame_done_q  <= frame_done_d;
            len_err_q     <= len_err_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    assign bus.reg_wr_en   = reg_wr_en_q;
    assign bus.reg_wr_addr = reg_wr_addr_q;
    assign bus.reg_wr_data = reg_wr_data_q;
    assign bus.ccw_wr      = ccw_wr_q;
    assign bus.ccw_data    = ccw_data_q;
    assign bus.ccw_len     = ccw_len_q;
    assign bus.ccw_len_vld = ccw_len_vld_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.len_err     = len_err_q;
    assign bus.ovf_err     = ovf_err_q;

endmodule
